regfile_2r1w: RTL and testbench

- Parametrised register file: two read ports, one write port. Next generation of the processor's single-port register store.
- Adds independent A/B read ports with registered outputs, write-to-read bypass, optional hardwired zero register, and a sequenced clear engine with a busy flag.
- Sits between decode (read addresses) and writeback (write port) in the processor datapath.

---
 rtl/regfile_2r1w_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 49 ++++
 rtl/regfile_2r1w.sv | 146 ++++++++++++++
 tb/tb_regfile_2r1w.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_2r1w_pkg.sv
// Shared constants and types for the two-read/one-write register file.
// Mode encoding, clear FSM states and the processor's default geometry.
package regfile_2r1w_pkg;

  localparam logic MODE_SCRIBBLE  = 1'b0;
  localparam logic MODE_INTERPRET = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range and zero-register screening, write-first
// bypass, and an output register that holds whenever no read is accepted.
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_accept,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] entry,
  input  logic              wr_accept,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic in_range;
  logic is_zero_reg;
  logic hit_write;

  always_comb begin
    in_range    = ({1'b0, raddr} < DEPTH_L);
    is_zero_reg = (ZERO_REG != 0) && (raddr == '0);
    hit_write   = wr_accept && (waddr == raddr);
  end

  // Screened addresses return zero and never bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_accept) begin
      if (!in_range || is_zero_reg) begin
        rdata <= '0;
      end else if (hit_write) begin
        rdata <= wdata;
      end else begin
        rdata <= entry;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two registered read ports, one write port, bypass,
// optional hardwired zero entry and a one-entry-per-cycle clear engine.
//
// state    | meaning
// ST_IDLE  | normal operation: writes, and reads when in interpret mode
// ST_CLEAR | zeroing entry clr_cnt each cycle; ports ignored, busy high
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid,
  input  logic              clear_req,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              busy_nxt;

  logic              idle;
  logic              waddr_ok;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W-1:0] entry_a;
  logic [DATA_W-1:0] entry_b;

  always_comb begin
    idle      = (state == ST_IDLE);
    waddr_ok  = ({1'b0, waddr} < DEPTH_L) && !((ZERO_REG != 0) && (waddr == '0));
    wr_accept = idle && write_enable && waddr_ok;
    rd_accept = idle && rd_en && (mode == MODE_INTERPRET);
    entry_a   = mem[raddr_a];
    entry_b   = mem[raddr_b];
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy_nxt    = busy;
    unique case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == CNT_LAST) begin
          state_nxt   = ST_IDLE;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        clr_cnt_nxt = '0;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      busy    <= busy_nxt;
      rvalid  <= rd_accept;
    end
  end

  // A write accepted alongside clear_req lands first; the sweep zeroes it later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .rd_accept (rd_accept),
    .raddr     (raddr_a),
    .entry     (entry_a),
    .wr_accept (wr_accept),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata_a)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .rd_accept (rd_accept),
    .raddr     (raddr_b),
    .entry     (entry_b),
    .wr_accept (wr_accept),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: directed reads push expected data,
// a negedge monitor pops and compares whenever rvalid is presented.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic        write_enable = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        rvalid;
  logic        clear_req = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a_q [$];
  logic [31:0] exp_b_q [$];
  int          exp_id_q [$];
  int          read_id = 0;

  regfile_2r1w #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .write_enable (write_enable),
    .waddr        (waddr),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .raddr_a      (raddr_a),
    .raddr_b      (raddr_b),
    .rdata_a      (rdata_a),
    .rdata_b      (rdata_b),
    .rvalid       (rvalid),
    .clear_req    (clear_req),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented read result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rvalid) begin
      if (exp_a_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: got rvalid=1 want no read pending (a=0x%08h)", rdata_a);
      end else begin
        int id;
        logic [31:0] ea, eb;
        id = exp_id_q.pop_front();
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        check($sformatf("read%0d_a", id), rdata_a, ea);
        check($sformatf("read%0d_b", id), rdata_b, eb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic [31:0] ea, input logic [31:0] eb);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_id_q.push_back(read_id);
    read_id++;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] ea, input logic [31:0] eb);
    mode = 1'b1;
    rd_en = 1'b1;
    raddr_a = ra;
    raddr_b = rb;
    expect_read(ea, eb);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_a_q.size() != 0 && n < 5) begin
      tick();
      n++;
    end
    if (exp_a_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d reads pending want 0", exp_a_q.size());
      exp_a_q.delete();
      exp_b_q.delete();
      exp_id_q.delete();
    end
  endtask

  task automatic run_clear(input string name, input bit poke_write);
    int n;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (poke_write && n == 10) begin
        write_enable = 1'b1;
        waddr = 5'd4;
        wdata = 32'hFF;
        mode = 1'b1;
        rd_en = 1'b1;
      end else begin
        write_enable = 1'b0;
        rd_en = 1'b0;
      end
      tick();
    end
    write_enable = 1'b0;
    rd_en = 1'b0;
    check({name, "_busy_cycles"}, 32'(n), 32'd32);
  endtask

  initial begin
    repeat (2) tick();
    check("reset_rdata_a", rdata_a, 32'h0);
    check("reset_rdata_b", rdata_b, 32'h0);
    check("reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    tick();

    do_read(5'd3, 5'd7, 32'h0, 32'h0);
    drain();

    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd6, 32'hDEADBEEF, 32'h0);
    drain();

    // bypass on both ports, then the zero register
    write_enable = 1'b1; waddr = 5'd9; wdata = 32'h12345678;
    do_read(5'd9, 5'd9, 32'h12345678, 32'h12345678);
    write_enable = 1'b1; waddr = 5'd0; wdata = 32'hCAFEF00D;
    do_read(5'd0, 5'd0, 32'h0, 32'h0);
    write_enable = 1'b0;
    do_read(5'd0, 5'd9, 32'h0, 32'h12345678);
    drain();

    // scribble: writes proceed, reads blocked, outputs hold
    do_read(5'd5, 5'd9, 32'hDEADBEEF, 32'h12345678);
    drain();
    mode = 1'b0;
    rd_en = 1'b1;
    raddr_a = 5'd2;
    raddr_b = 5'd2;
    do_write(5'd2, 32'hA5A5A5A5);
    rd_en = 1'b0;
    check("scribble_rvalid", {31'b0, rvalid}, 32'h0);
    check("scribble_hold_a", rdata_a, 32'hDEADBEEF);
    check("scribble_hold_b", rdata_b, 32'h12345678);
    do_read(5'd2, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF);
    drain();

    // fill, clear, and confirm the sweep
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    do_read(5'd1, 5'd31, 32'd1, 32'd31);
    drain();
    run_clear("clear", 1'b1);
    check("post_clear_busy", {31'b0, busy}, 32'h0);
    for (int i = 1; i < 32; i += 2) do_read(5'(i), 5'(i + 1), 32'h0, 32'h0);
    do_read(5'd4, 5'd4, 32'h0, 32'h0);
    drain();

    // reset in the middle of a clear
    do_write(5'd20, 32'h20);
    do_write(5'd6, 32'h66);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    check("midclear_busy_before", {31'b0, busy}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("midclear_busy_async", {31'b0, busy}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    do_read(5'd20, 5'd6, 32'h0, 32'h0);
    drain();
    do_write(5'd7, 32'h77);
    run_clear("restart_clear", 1'b0);
    do_read(5'd7, 5'd1, 32'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
